// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_arbiter
// Description : Round-robin front end that shares one pipelined FP16 adder
//               between two requesters. A shadow pipeline tracks the owner of
//               each in-flight operation and steers each result back to it.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arbiter #(
    // Clock edges from an adder input change to a valid adder output (1..8).
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_op,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_op,

    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_op,
    input  logic [15:0] add_s,

    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [15:0] resp_s,
    output logic        resp_special,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // Arbitration state and issue registers
    // ------------------------------------------------------------------------
    logic        last_grant_q, last_grant_d;
    logic        grant;
    logic        handshake;

    logic [15:0] add_a_q, add_a_d;
    logic [15:0] add_b_q, add_b_d;
    logic        add_op_q, add_op_d;

    // Shadow pipeline: bit k of each vector is stage k; stage LATENCY retires.
    logic [LATENCY:0] sh_valid_q, sh_valid_d;
    logic [LATENCY:0] sh_owner_q, sh_owner_d;

    logic        retire;
    logic        retire_owner;

    logic        resp0_valid_q, resp0_valid_d;
    logic        resp1_valid_q, resp1_valid_d;
    logic [15:0] resp_s_q, resp_s_d;
    logic        resp_special_q, resp_special_d;

    // Round-robin grant: under contention the requester that did not win last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is qualified by valid so an idle requester never sees ready.
    assign req0_ready = req0_valid & ~grant;
    assign req1_ready = req1_valid &  grant;
    assign handshake  = req0_ready | req1_ready;

    // Next-state for grant history and the adder operand registers.
    always_comb begin
        last_grant_d = last_grant_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_op_d     = add_op_q;
        if (handshake) begin
            last_grant_d = grant;
            add_a_d      = grant ? req1_a  : req0_a;
            add_b_d      = grant ? req1_b  : req0_b;
            add_op_d     = grant ? req1_op : req0_op;
        end
    end

    // Shadow pipeline shifts every cycle; stage 0 records this cycle's issue.
    always_comb begin
        sh_valid_d = {sh_valid_q[LATENCY-1:0], handshake};
        sh_owner_d = {sh_owner_q[LATENCY-1:0], grant};
    end

    assign retire       = sh_valid_q[LATENCY];
    assign retire_owner = sh_owner_q[LATENCY];

    // Response capture: the adder output is valid while the last stage is.
    always_comb begin
        resp0_valid_d  = retire & ~retire_owner;
        resp1_valid_d  = retire &  retire_owner;
        resp_s_d       = resp_s_q;
        resp_special_d = resp_special_q;
        if (retire) begin
            resp_s_d       = add_s;
            resp_special_d = &add_s[14:10];
        end
    end

    // State registers; reset drops all in-flight work and favours req0 next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q   <= 1'b1;
            add_a_q        <= 16'h0000;
            add_b_q        <= 16'h0000;
            add_op_q       <= 1'b0;
            sh_valid_q     <= '0;
            sh_owner_q     <= '0;
            resp0_valid_q  <= 1'b0;
            resp1_valid_q  <= 1'b0;
            resp_s_q       <= 16'h0000;
            resp_special_q <= 1'b0;
        end else begin
            last_grant_q   <= last_grant_d;
            add_a_q        <= add_a_d;
            add_b_q        <= add_b_d;
            add_op_q       <= add_op_d;
            sh_valid_q     <= sh_valid_d;
            sh_owner_q     <= sh_owner_d;
            resp0_valid_q  <= resp0_valid_d;
            resp1_valid_q  <= resp1_valid_d;
            resp_s_q       <= resp_s_d;
            resp_special_q <= resp_special_d;
        end
    end

    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign add_op       = add_op_q;
    assign resp0_valid  = resp0_valid_q;
    assign resp1_valid  = resp1_valid_q;
    assign resp_s       = resp_s_q;
    assign resp_special = resp_special_q;
    assign busy         = |sh_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_arbiter
// Description : Directed self-checking bench for fp_add_arbiter, with a
//               LATENCY=1 instance and a LATENCY=3 instance, each driving a
//               table-based pipelined adder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    // LATENCY=1 instance signals
    logic        req0_valid, req0_ready, req0_op;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [15:0] req1_a, req1_b;
    logic [15:0] add_a, add_b, add_s;
    logic        add_op;
    logic        resp0_valid, resp1_valid, resp_special, busy;
    logic [15:0] resp_s;

    // LATENCY=3 instance signals
    logic        r0v3, r0r3, r0op3;
    logic [15:0] r0a3, r0b3;
    logic        r1v3, r1r3, r1op3;
    logic [15:0] r1a3, r1b3;
    logic [15:0] add_a3, add_b3, add_s3;
    logic        add_op3;
    logic        rv0_3, rv1_3, rsp_3, busy3;
    logic [15:0] rs3;

    fp_add_arbiter #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op),
        .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_s(add_s),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_s(resp_s),
        .resp_special(resp_special), .busy(busy)
    );

    fp_add_arbiter #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v3), .req0_ready(r0r3), .req0_a(r0a3),
        .req0_b(r0b3), .req0_op(r0op3),
        .req1_valid(r1v3), .req1_ready(r1r3), .req1_a(r1a3),
        .req1_b(r1b3), .req1_op(r1op3),
        .add_a(add_a3), .add_b(add_b3), .add_op(add_op3), .add_s(add_s3),
        .resp0_valid(rv0_3), .resp1_valid(rv1_3), .resp_s(rs3),
        .resp_special(rsp_3), .busy(busy3)
    );

    // Adder behaviour for the operand pairs used in this bench.
    function automatic logic [15:0] fp_model(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic op);
        logic [32:0] key;
        key = {a, b, op};
        case (key)
            {16'h4724, 16'h4ACC, 1'b0}: return 16'h4D2F;
            {16'h4724, 16'h4ACC, 1'b1}: return 16'hC674;
            {16'h4724, 16'h4724, 1'b0}: return 16'h4B24;
            {16'h4724, 16'h4724, 1'b1}: return 16'h0000;
            {16'h7C00, 16'h4724, 1'b0}: return 16'h7C00;
            default:                    return 16'hDEAD;
        endcase
    endfunction

    // One-stage adder model
    always @(posedge clk) add_s <= fp_model(add_a, add_b, add_op);

    // Three-stage adder model
    logic [15:0] p3_0, p3_1;
    always @(posedge clk) begin
        p3_0   <= fp_model(add_a3, add_b3, add_op3);
        p3_1   <= p3_0;
        add_s3 <= p3_1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        r0v3 = 0; r1v3 = 0; r0op3 = 0; r1op3 = 0;
        r0a3 = 0; r0b3 = 0; r1a3 = 0; r1b3 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #1 rst_n = 0;
        step();
        step();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 0;
        step();
        n_tests++;
        if ({add_a, add_b, add_op, resp_s, resp0_valid, resp1_valid, resp_special, busy,
             req0_ready, req1_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got a=%h b=%h op=%b s=%h v0=%b v1=%b sp=%b busy=%b rdy=%b%b want all 0",
                     add_a, add_b, add_op, resp_s, resp0_valid, resp1_valid, resp_special, busy,
                     req0_ready, req1_ready);
        end
        n_tests++;
        if ({add_a3, rs3, rv0_3, rv1_3, busy3} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_l3: got a=%h s=%h v0=%b v1=%b busy=%b want all 0",
                     add_a3, rs3, rv0_3, rv1_3, busy3);
        end
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if ({req0_ready, req1_ready, busy, resp0_valid, resp1_valid} !== 5'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc%0d: got rdy=%b%b busy=%b v=%b%b want 0",
                         i, req0_ready, req1_ready, busy, resp0_valid, resp1_valid);
            end
        end
    endtask

    // Single req0 op; response expected on the third cycle after the request cycle.
    task automatic single_req0(input logic op, input logic [15:0] exp_s, input string nm);
        req0_valid = 1; req0_a = 16'h4724; req0_b = 16'h4ACC; req0_op = op;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready: got rdy0=%b rdy1=%b want 1 0", nm, req0_ready, req1_ready);
        end
        step();
        req0_valid = 0;
        n_tests++;
        if (busy !== 1'b1 || resp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_inflight: got busy=%b v0=%b want 1 0", nm, busy, resp0_valid);
        end
        step();
        n_tests++;
        if (resp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_early: got v0=%b want 0", nm, resp0_valid);
        end
        step();
        n_tests++;
        if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp_s !== exp_s ||
            resp_special !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_resp: got v0=%b v1=%b s=%h sp=%b want 1 0 %h 0",
                     nm, resp0_valid, resp1_valid, resp_s, resp_special, exp_s);
        end
        step();
        n_tests++;
        if (resp0_valid !== 1'b0 || resp_s !== exp_s || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after: got v0=%b s=%h busy=%b want 0 %h 0",
                     nm, resp0_valid, resp_s, busy, exp_s);
        end
    endtask

    task automatic test_single();
        single_req0(1'b0, 16'h4D2F, "single_add");
        single_req0(1'b1, 16'hC674, "single_sub");
    endtask

    task automatic test_back_to_back();
        logic        exp_v0, exp_v1;
        logic [15:0] exp_s;
        do_reset();
        req0_a = 16'h4724; req0_b = 16'h4724; req0_op = 0;
        req1_a = 16'h4724; req1_b = 16'h4724; req1_op = 1;
        for (int i = 0; i < 8; i++) begin
            req0_valid = (i < 4);
            req1_valid = (i < 4);
            #1;
            if (i < 4) begin
                n_tests++;
                if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL b2b_grant cyc%0d: got rdy=%b%b want %b%b", i,
                             req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
                end
            end
            exp_v0 = (i == 3) || (i == 5);
            exp_v1 = (i == 4) || (i == 6);
            exp_s  = exp_v1 ? 16'h0000 : 16'h4B24;
            n_tests++;
            if (resp0_valid !== exp_v0 || resp1_valid !== exp_v1 ||
                ((exp_v0 || exp_v1) && resp_s !== exp_s)) begin
                n_fail++;
                $display("FAIL b2b_resp cyc%0d: got v=%b%b s=%h want v=%b%b s=%h", i,
                         resp0_valid, resp1_valid, resp_s, exp_v0, exp_v1, exp_s);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_special();
        req1_valid = 1; req1_a = 16'h7C00; req1_b = 16'h4724; req1_op = 0;
        #1;
        n_tests++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL special_ready: got rdy=%b%b want 01", req0_ready, req1_ready);
        end
        step();
        req1_valid = 0;
        step();
        step();
        n_tests++;
        if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp_special !== 1'b1 ||
            resp_s[14:10] !== 5'b11111) begin
            n_fail++;
            $display("FAIL special_resp: got v=%b%b sp=%b s=%h want v=01 sp=1 exp=1f",
                     resp0_valid, resp1_valid, resp_special, resp_s);
        end
        step();
        n_tests++;
        if (resp1_valid !== 1'b0 || resp_special !== 1'b1) begin
            n_fail++;
            $display("FAIL special_hold: got v1=%b sp=%b want 0 1", resp1_valid, resp_special);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen = 0;
        // Leave last_grant at 0 so a correct reset must restore it to 1.
        req0_valid = 1; req0_a = 16'h4724; req0_b = 16'h4ACC; req0_op = 0;
        step();
        req0_valid = 0;
        rst_n = 0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || add_a !== 16'h0000 || resp_s !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_clear: got busy=%b a=%h s=%h want 0 0 0", busy, add_a, resp_s);
        end
        step();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp0_valid === 1'b1 || resp1_valid === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_noresp: got pulses=%0d busy=%b want 0 0", seen, busy);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_grant: got rdy=%b%b want 10", req0_ready, req1_ready);
        end
        idle_inputs();
        step(); step(); step(); step();
    endtask

    task automatic test_latency3();
        logic [15:0] exp_tab [3];
        logic        exp_v;
        exp_tab[0] = 16'h4D2F; exp_tab[1] = 16'hC674; exp_tab[2] = 16'h4B24;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            r0v3 = (i < 3);
            r0a3 = 16'h4724;
            r0b3 = (i == 2) ? 16'h4724 : 16'h4ACC;
            r0op3 = (i == 1);
            #1;
            if (i < 3) begin
                n_tests++;
                if (r0r3 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL l3_ready cyc%0d: got %b want 1", i, r0r3);
                end
            end
            exp_v = (i >= 5) && (i <= 7);
            n_tests++;
            if (rv0_3 !== exp_v || rv1_3 !== 1'b0 || (exp_v && rs3 !== exp_tab[i-5])) begin
                n_fail++;
                $display("FAIL l3_resp cyc%0d: got v=%b%b s=%h want v=%b0 s=%h", i,
                         rv0_3, rv1_3, rs3, exp_v, exp_v ? exp_tab[i-5] : 16'h0);
            end
            step();
        end
        n_tests++;
        if (busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL l3_busy_end: got %b want 0", busy3);
        end
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_special();
        test_reset_midflight();
        test_latency3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
